pc_fetch_unit: RTL and testbench
================================

# pc_fetch_unit

Program-counter stage that consumes the word-aligned branch offset produced by the 32-bit shift-left-by-2 stage. It holds the architectural PC and computes PC+4, branch and jump targets. It issues fetch requests to instruction memory over a valid/ready handshake. Redirects (branch, jump, jr) that arrive while the fetch is back-pressured or stalled are buffered. A misaligned jr target produces an address-error flag and a vector redirect.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded by reset
- EXC_VECTOR, 32'h0000_0180, redirect target on misaligned jr
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- stall  in  1  hazard hold; PC must not advance while high
- imem_ready  in  1  instruction memory accepts the current request
- branch_taken  in  1  conditional branch resolved taken (one-cycle pulse)
- branch_offset_sl2  in  32  sign-extended offset already shifted left by 2
- jump  in  1  j/jal redirect pulse
- jump_index  in  26  instr[25:0]
- jr  in  1  register-jump redirect pulse
- jr_target  in  32  rs value
- pc  out  32  current fetch address (registered)
- pc_plus4  out  32  pc + 4 (combinational from pc)
- imem_valid  out  1  fetch request valid (registered)
- addr_err  out  1  one-cycle pulse: misaligned jr seen

## Operation
- Reset state: pc=RESET_PC, imem_valid=0, addr_err=0, pend_valid=0, pend_pc=0, FSM=BOOT.
- FSM has two states:
  - BOOT → RUN unconditionally on the first clock after reset release; imem_valid is 0 in BOOT.
  - RUN: imem_valid=1. The FSM never returns to BOOT except via rst_n.
- advance = imem_valid & imem_ready & ~stall.
- Redirect source priority, applied when more than one is asserted in the same cycle: jr > jump > branch_taken.
- Target computation (all arithmetic mod 2^32, wrap-around silent):
  - Branch: pc_plus4 + branch_offset_sl2.
  - Jump: {pc_plus4[31:28], jump_index, 2'b00}.
  - jr with jr_target[1:0]==0: jr_target.
  - jr with jr_target[1:0]!=0: EXC_VECTOR; addr_err=1 next cycle for exactly one cycle.
- Next pc when advance=1:
  - redirect this cycle → its target;
  - else pend_valid → pend_pc, and pend_valid clears;
  - else pc_plus4.
- When advance=0 and a redirect is present: pend_pc ← target, pend_valid ← 1. A later redirect overwrites the pending one (newest wins). pc holds.
- When advance=0 and no redirect: pc, pend_pc and pend_valid all hold.
- Redirect together with advance=1 and pend_valid=1: the new redirect wins and pend_valid clears.
- Reset asserted mid-operation: every register returns to its reset value immediately (asynchronous); a pending redirect is discarded.

## Timing
- All outputs except pc_plus4 are registered.
- Redirect latency: a target presented in cycle N with advance=1 appears on pc in N+1.
- Buffered redirect: appears on pc one cycle after the first advance.
- First fetch: imem_valid rises one cycle after rst_n deasserts, with pc=RESET_PC. That PC stays presented until imem_ready & ~stall.
- pc and imem_valid are stable while imem_valid=1 and imem_ready=0 (handshake hold rule).
- addr_err asserts the cycle after the misaligned jr is sampled, whether or not advance was 1.

## Structure
- Shared package mips_pc_pkg holds:
  - RESET_PC and EXC_VECTOR default constants;
  - the FSM state type {BOOT, RUN};
  - the redirect-source type {RD_NONE, RD_BRANCH, RD_JUMP, RD_JR, RD_EXC}.
- One sub-module, pc_target_mux. It is purely combinational: priority select plus target and misalignment computation, and outputs redirect_valid, redirect_pc and misaligned.
- The top level holds the FSM, pc, pending buffer and addr_err registers.

## Test plan
- Reset release, imem_ready=1, no redirects → imem_valid=0 for 1 cycle, then pc = 0x0, 0x4, 0x8 on successive cycles.
- pc=0x100, branch_taken with branch_offset_sl2=0xFFFF_FFF0 → next pc=0x0F4. Wrap case: pc=0xFFFF_FFFC, no redirect → next pc=0x0.
- pc=0x1000_0040, jump with jump_index=0x0000_200 → next pc=0x1000_0800. Same cycle as branch_taken → jump target wins.
- Redirect during back-pressure:
  - Setup: imem_ready=0 with jr to 0x2000, then the next cycle branch to 0x3000.
  - While ready=0: pc holds.
  - After ready=1: pc=0x3000 one cycle later, then pc=0x3004.
- jr_target=0x2002 → pc=0x180 and addr_err high for exactly one cycle. Same case with stall=1 → addr_err still pulses, and pc=0x180 once stall drops.
- Assert rst_n=0 mid-run with pend_valid=1 → pc=RESET_PC and imem_valid=0 immediately. After release, the sequence restarts from 0x0 with no pending redirect applied.

Source files
------------

// File: rtl/mips_pc_pkg.sv
// Shared definitions for the MIPS program-counter fetch stage.
//   DEF_RESET_PC   : PC loaded by reset
//   DEF_EXC_VECTOR : redirect target taken on a misaligned jr
//   pc_state_t     : fetch FSM state encoding
//   redirect_src_t : which redirect source won the priority select
package mips_pc_pkg;

  localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_0180;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } pc_state_t;

  typedef enum logic [2:0] {
    RD_NONE   = 3'd0,
    RD_BRANCH = 3'd1,
    RD_JUMP   = 3'd2,
    RD_JR     = 3'd3,
    RD_EXC    = 3'd4
  } redirect_src_t;

endpackage

// File: rtl/pc_target_mux.sv
// Combinational redirect select for the fetch stage.
// Picks the winning redirect source (jr > jump > branch) and computes its
// target. A jr with a non-word-aligned target is turned into a redirect to
// the exception vector and flagged as misaligned.
// Ports:
//   pc_plus4          in  32  pc + 4 of the current fetch
//   branch_taken      in  1   conditional branch taken
//   branch_offset_sl2 in  32  sign-extended, pre-shifted branch offset
//   jump              in  1   j/jal redirect
//   jump_index        in  26  instr[25:0]
//   jr                in  1   register-jump redirect
//   jr_target         in  32  rs value
//   redirect_valid    out 1   some redirect is present this cycle
//   redirect_pc       out 32  target of the winning redirect
//   misaligned        out 1   winning redirect is a misaligned jr
module pc_target_mux
  import mips_pc_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
  input  logic [31:0] pc_plus4,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset_sl2,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        misaligned
);

  redirect_src_t src;

  always_comb begin
    src = RD_NONE;
    if (jr) begin
      src = (jr_target[1:0] != 2'b00) ? RD_EXC : RD_JR;
    end else if (jump) begin
      src = RD_JUMP;
    end else if (branch_taken) begin
      src = RD_BRANCH;
    end
  end

  always_comb begin
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    misaligned     = 1'b0;
    case (src)
      RD_BRANCH: begin
        redirect_valid = 1'b1;
        redirect_pc    = pc_plus4 + branch_offset_sl2;
      end
      RD_JUMP: begin
        redirect_valid = 1'b1;
        // j/jal stay inside the 256 MB region of the delay-slot PC
        redirect_pc    = {pc_plus4[31:28], jump_index, 2'b00};
      end
      RD_JR: begin
        redirect_valid = 1'b1;
        redirect_pc    = jr_target;
      end
      RD_EXC: begin
        redirect_valid = 1'b1;
        redirect_pc    = EXC_VECTOR;
        misaligned     = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program-counter stage: holds the PC, issues fetch requests over a
// valid/ready handshake, and applies or buffers branch/jump/jr redirects.
//
//   state | meaning
//   ------+------------------------------------------------------
//   BOOT  | first cycle after reset; no fetch request issued
//   RUN   | fetch request always valid; left only via rst_n
//
// Ports:
//   clk, rst_n        in      clock, async active-low reset
//   stall             in  1   hazard hold
//   imem_ready        in  1   instruction memory accepts request
//   branch_taken      in  1   branch resolved taken
//   branch_offset_sl2 in  32  pre-shifted branch offset
//   jump, jump_index  in  1/26 j/jal redirect
//   jr, jr_target     in  1/32 register-jump redirect
//   pc                out 32  current fetch address
//   pc_plus4          out 32  pc + 4
//   imem_valid        out 1   fetch request valid
//   addr_err          out 1   misaligned jr seen last cycle
module pc_fetch_unit
  import mips_pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
  parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        imem_ready,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset_sl2,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        imem_valid,
  output logic        addr_err
);

  pc_state_t   state, state_nxt;
  logic        imem_valid_nxt;
  logic        advance;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        misaligned;
  logic        pend_valid;
  logic [31:0] pend_pc;

  assign pc_plus4 = pc + 32'd4;
  assign advance  = imem_valid & imem_ready & ~stall;

  pc_target_mux #(
    .EXC_VECTOR (EXC_VECTOR)
  ) u_target_mux (
    .pc_plus4          (pc_plus4),
    .branch_taken      (branch_taken),
    .branch_offset_sl2 (branch_offset_sl2),
    .jump              (jump),
    .jump_index        (jump_index),
    .jr                (jr),
    .jr_target         (jr_target),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .misaligned        (misaligned)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= BOOT;
      imem_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      imem_valid <= imem_valid_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    imem_valid_nxt = 1'b0;
    case (state)
      BOOT: state_nxt = RUN;
      RUN:  state_nxt = RUN;
      default: state_nxt = BOOT;
    endcase
    imem_valid_nxt = (state_nxt == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      pend_valid <= 1'b0;
      pend_pc    <= '0;
      addr_err   <= 1'b0;
    end else begin
      // flagged on sampling, independent of whether the fetch advanced
      addr_err <= misaligned;
      if (advance) begin
        // a fresh redirect supersedes anything still buffered
        if (redirect_valid) begin
          pc <= redirect_pc;
        end else if (pend_valid) begin
          pc <= pend_pc;
        end else begin
          pc <= pc_plus4;
        end
        pend_valid <= 1'b0;
      end else if (redirect_valid) begin
        pend_pc    <= redirect_pc;
        pend_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        imem_ready;
  logic        branch_taken;
  logic [31:0] branch_offset_sl2;
  logic        jump;
  logic [25:0] jump_index;
  logic        jr;
  logic [31:0] jr_target;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        imem_valid;
  logic        addr_err;

  always #5 clk = ~clk;

  pc_fetch_unit dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .stall             (stall),
    .imem_ready        (imem_ready),
    .branch_taken      (branch_taken),
    .branch_offset_sl2 (branch_offset_sl2),
    .jump              (jump),
    .jump_index        (jump_index),
    .jr                (jr),
    .jr_target         (jr_target),
    .pc                (pc),
    .pc_plus4          (pc_plus4),
    .imem_valid        (imem_valid),
    .addr_err          (addr_err)
  );

  typedef struct {
    logic        stall;
    logic        ready;
    logic        br;
    logic [31:0] off;
    logic        jmp;
    logic [25:0] idx;
    logic        jr;
    logic [31:0] jrt;
    logic [31:0] exp_pc;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic        valid;
    logic        err;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic vec_t mk(logic s, logic r, logic b, logic [31:0] o,
                              logic j, logic [25:0] ix, logic rj,
                              logic [31:0] rt, logic [31:0] epc, logic ee);
    vec_t v;
    v.stall = s; v.ready = r; v.br = b; v.off = o; v.jmp = j; v.idx = ix;
    v.jr = rj; v.jrt = rt; v.exp_pc = epc; v.exp_err = ee;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic clear_inputs();
    stall = 1'b0; imem_ready = 1'b1; branch_taken = 1'b0;
    branch_offset_sl2 = '0; jump = 1'b0; jump_index = '0;
    jr = 1'b0; jr_target = '0;
  endtask

  // drive one cycle of stimulus, queue its expectation, compare after the edge
  task automatic apply(vec_t v, string tag);
    exp_t e;
    exp_t got;
    stall = v.stall; imem_ready = v.ready; branch_taken = v.br;
    branch_offset_sl2 = v.off; jump = v.jmp; jump_index = v.idx;
    jr = v.jr; jr_target = v.jrt;
    e.pc = v.exp_pc; e.valid = 1'b1; e.err = v.exp_err;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_total++;
      $display("FAIL %s scoreboard: got empty expected entry", tag);
    end else begin
      got = sb.pop_front();
      chk({tag, " pc"}, pc, got.pc);
      chk({tag, " pc_plus4"}, pc_plus4, got.pc + 32'd4);
      chk({tag, " imem_valid"}, {31'd0, imem_valid}, {31'd0, got.valid});
      chk({tag, " addr_err"}, {31'd0, addr_err}, {31'd0, got.err});
    end
  endtask

  initial begin
    // stall ready br off jmp idx jr jrt exp_pc err
    vecs.push_back(mk(0,1,0,0,0,0,0,0, 32'h0000_0000,0));
    vecs.push_back(mk(0,1,0,0,0,0,0,0, 32'h0000_0004,0));
    vecs.push_back(mk(0,1,0,0,0,0,0,0, 32'h0000_0008,0));
    vecs.push_back(mk(0,1,0,0,0,0,1,32'h0000_0100, 32'h0000_0100,0));
    vecs.push_back(mk(0,1,1,32'hFFFF_FFF0,0,0,0,0, 32'h0000_00F4,0));
    vecs.push_back(mk(0,1,0,0,0,0,1,32'hFFFF_FFFC, 32'hFFFF_FFFC,0));
    vecs.push_back(mk(0,1,0,0,0,0,0,0, 32'h0000_0000,0));
    vecs.push_back(mk(0,1,0,0,0,0,1,32'h1000_0040, 32'h1000_0040,0));
    vecs.push_back(mk(0,1,0,0,1,26'h200,0,0, 32'h1000_0800,0));
    vecs.push_back(mk(0,1,1,32'h100,1,26'h10,0,0, 32'h1000_0040,0));
    vecs.push_back(mk(0,1,1,32'h4,1,26'h3,1,32'h500, 32'h0000_0500,0));
    vecs.push_back(mk(0,1,0,0,0,0,1,32'h2002, 32'h0000_0180,1));
    vecs.push_back(mk(0,1,0,0,0,0,0,0, 32'h0000_0184,0));
    vecs.push_back(mk(1,1,0,0,0,0,0,0, 32'h0000_0184,0));
    vecs.push_back(mk(0,0,0,0,0,0,1,32'h2000, 32'h0000_0184,0));
    vecs.push_back(mk(0,0,1,32'h2E78,0,0,0,0, 32'h0000_0184,0));
    vecs.push_back(mk(0,1,0,0,0,0,0,0, 32'h0000_3000,0));
    vecs.push_back(mk(0,1,0,0,0,0,0,0, 32'h0000_3004,0));
    vecs.push_back(mk(1,1,0,0,0,0,1,32'h2002, 32'h0000_3004,1));
    vecs.push_back(mk(1,1,0,0,0,0,0,0, 32'h0000_3004,0));
    vecs.push_back(mk(0,1,0,0,0,0,0,0, 32'h0000_0180,0));
    vecs.push_back(mk(0,1,0,0,0,0,0,0, 32'h0000_0184,0));
    vecs.push_back(mk(0,0,0,0,0,0,1,32'h400, 32'h0000_0184,0));
    vecs.push_back(mk(0,1,0,0,0,0,1,32'h600, 32'h0000_0600,0));
    vecs.push_back(mk(0,1,0,0,0,0,0,0, 32'h0000_0604,0));

    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk("reset pc", pc, 32'h0);
    chk("reset imem_valid", {31'd0, imem_valid}, 32'd0);
    chk("reset addr_err", {31'd0, addr_err}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("boot imem_valid", {31'd0, imem_valid}, 32'd0);

    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // buffer a redirect, then reset mid-cycle: it must be discarded
    apply(mk(0,0,0,0,0,0,1,32'h800, 32'h0000_0604,0), "pend_before_rst");
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst pc", pc, 32'h0);
    chk("midrst imem_valid", {31'd0, imem_valid}, 32'd0);
    chk("midrst addr_err", {31'd0, addr_err}, 32'd0);
    clear_inputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("reboot imem_valid", {31'd0, imem_valid}, 32'd0);
    apply(mk(0,1,0,0,0,0,0,0, 32'h0000_0000,0), "restart0");
    apply(mk(0,1,0,0,0,0,0,0, 32'h0000_0004,0), "restart1");
    apply(mk(0,1,0,0,0,0,0,0, 32'h0000_0008,0), "restart2");

    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL scoreboard drain: got %0d expected 0", sb.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
